// File: rtl/ram_lsu.sv
// Dual-port word RAM: 1-cycle registered fetch port plus one-outstanding load/store port.
// Loads answer after LAT cycles, stores/faults after 1; d_ready is low while a request is in flight.
module ram_lsu #(
   parameter int ADDR_W = 14,
   parameter int LAT    = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_valid,
   output logic [31:0]       i_data,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [1:0]        d_size,
   input  logic              d_unsigned,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [31:0]       d_wdata,
   output logic              d_ready,
   output logic              d_valid,
   output logic [31:0]       d_rdata,
   output logic              d_fault
);

   localparam int DEPTH = 2 ** (ADDR_W - 2);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   typedef struct packed {
      logic [31:0] rdata;
      logic        fault;
   } resp_t;

   logic [31:0]       mem [DEPTH];
   state_t            state;
   logic [2:0]        cnt;
   resp_t             pend;
   resp_t             resp_now;
   logic [ADDR_W-3:0] i_widx;
   logic [ADDR_W-3:0] d_widx;
   logic              accept;
   logic              fault;
   logic [3:0]        lane_en;
   logic [31:0]       wdata_l;
   logic [31:0]       rd_word;
   logic [7:0]        ld_b;
   logic [15:0]       ld_h;
   logic [31:0]       ld_data;
   logic              unused_i_addr;

   assign i_widx        = i_addr[ADDR_W-1:2];
   assign d_widx        = d_addr[ADDR_W-1:2];
   assign unused_i_addr = ^i_addr[1:0];
   assign d_ready       = (state == IDLE);
   assign accept        = d_req & d_ready;
   assign rd_word       = mem[d_widx];

   always_comb begin
      fault = 1'b0;
      case (d_size)
         2'b00:   fault = 1'b0;
         2'b01:   fault = d_addr[0];
         2'b10:   fault = (d_addr[1:0] != 2'b00);
         default: fault = 1'b1;
      endcase
   end

   // Store data is replicated across lanes so the lane enable alone picks the target bytes.
   always_comb begin
      lane_en = 4'b0000;
      wdata_l = d_wdata;
      case (d_size)
         2'b00: begin
            lane_en = 4'b0001 << d_addr[1:0];
            wdata_l = {4{d_wdata[7:0]}};
         end
         2'b01: begin
            lane_en = d_addr[1] ? 4'b1100 : 4'b0011;
            wdata_l = {2{d_wdata[15:0]}};
         end
         default: begin
            lane_en = 4'b1111;
            wdata_l = d_wdata;
         end
      endcase
   end

   always_comb begin
      ld_b    = rd_word[{d_addr[1:0], 3'b000} +: 8];
      ld_h    = rd_word[{d_addr[1], 4'b0000} +: 16];
      ld_data = rd_word;
      case (d_size)
         2'b00:   ld_data = d_unsigned ? {24'd0, ld_b} : {{24{ld_b[7]}}, ld_b};
         2'b01:   ld_data = d_unsigned ? {16'd0, ld_h} : {{16{ld_h[15]}}, ld_h};
         default: ld_data = rd_word;
      endcase
   end

   always_comb begin
      resp_now = '0;
      if (fault) begin
         resp_now.fault = 1'b1;
      end else if (!d_we) begin
         resp_now.rdata = ld_data;
      end
   end

   // No reset on the array: contents survive reset, and a reset edge blocks the write.
   always_ff @(posedge clk) begin
      if (reset_n && accept && d_we && !fault) begin
         for (int b = 0; b < 4; b++) begin
            if (lane_en[b]) begin
               mem[d_widx][8*b +: 8] <= wdata_l[8*b +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state   <= IDLE;
         cnt     <= 3'd0;
         pend    <= '0;
         i_valid <= 1'b0;
         i_data  <= 32'd0;
         d_valid <= 1'b0;
         d_rdata <= 32'd0;
         d_fault <= 1'b0;
      end else begin
         i_valid <= i_req;
         if (i_req) begin
            i_data <= mem[i_widx];
         end
         d_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  if (d_we || fault || (LAT == 1)) begin
                     state   <= RESP;
                     d_valid <= 1'b1;
                     d_rdata <= resp_now.rdata;
                     d_fault <= resp_now.fault;
                  end else begin
                     state <= WAIT;
                     pend  <= resp_now;
                     cnt   <= 3'd1;
                  end
               end
            end
            WAIT: begin
               if (cnt == 3'(LAT - 1)) begin
                  state   <= RESP;
                  d_valid <= 1'b1;
                  d_rdata <= pend.rdata;
                  d_fault <= pend.fault;
               end else begin
                  cnt <= cnt + 3'd1;
               end
            end
            RESP: begin
               state <= IDLE;
               cnt   <= 3'd0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
